spi_master_transmitter: RTL

SPI master (mode 0, MSB first) that drives the far end of the link served by the SPI slave receiver. It pulls words from a push-style transmit source and serialises them on `mosi`. It captures the words the slave returns on `miso` and presents them to a push-style receive sink. It sits on the host/bridge side of the mil1553-spi design and is the bench driver and the production master for that interface.

---
 rtl/spi_master_transmitter.sv | 96 +++++++++
 1 files changed

// File: rtl/spi_master_transmitter.sv
// spi_master_transmitter: SPI mode-0 master, MSB first, push-style transmit source and receive sink
module spi_master_transmitter #(
  parameter int WORD_WIDTH = 16,
  parameter int CLK_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_IDLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] tData,
  input  logic                  tRequest,
  output logic                  tDone,
  output logic [WORD_WIDTH-1:0] rData,
  output logic                  rRequest,
  input  logic                  rDone,
  output logic                  overflow,
  output logic                  busy,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  nCS
);
  localparam int CMAX = CLK_DIV > CS_SETUP ? (CLK_DIV > CS_IDLE ? CLK_DIV : CS_IDLE)
                                           : (CS_SETUP > CS_IDLE ? CS_SETUP : CS_IDLE);
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} stateType;
  stateType state, stateNext;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitCnt;
  logic [WORD_WIDTH-1:0] txShift, rxShift;
  logic [1:0] misoSync;
  logic halfEnd, wordEnd, load, toGap;
  assign busy = state != IDLE;
  // bitCnt reaches WORD_WIDTH only after the last falling edge, so wordEnd fires once per word
  always_comb begin
    halfEnd = cnt == CW'(CLK_DIV - 1);
    wordEnd = state == SHIFT && !sck && cnt == '0 && bitCnt == BW'(WORD_WIDTH);
    toGap = state == SHIFT && !sck && halfEnd && bitCnt == BW'(WORD_WIDTH);
    load = (state == IDLE || wordEnd) && tRequest;
    stateNext = state;
    case (state)
      IDLE:    stateNext = tRequest ? SETUP : IDLE;
      SETUP:   stateNext = cnt == CW'(CS_SETUP - 1) ? SHIFT : SETUP;
      SHIFT:   stateNext = toGap ? GAP : SHIFT;
      default: stateNext = cnt == CW'(CS_IDLE - 1) ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge clk) begin
    misoSync <= {misoSync[0], miso};
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bitCnt <= '0;
      txShift <= '0;
      rxShift <= '0;
      sck <= 1'b0;
      nCS <= 1'b1;
      mosi <= 1'b0;
      tDone <= 1'b0;
      rData <= '0;
      rRequest <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= stateNext;
      tDone <= load;
      cnt <= (state == IDLE || state != stateNext || (state == SHIFT && halfEnd)) ? '0 : cnt + 1'b1;
      if (load) begin
        txShift <= {tData[WORD_WIDTH-2:0], 1'b0};
        mosi <= tData[WORD_WIDTH-1];
        nCS <= 1'b0;
        bitCnt <= '0;
      end
      if (stateNext == SHIFT && (state == SETUP || halfEnd)) sck <= !sck;
      if (state == SHIFT && sck && halfEnd) begin
        bitCnt <= bitCnt + 1'b1;
        if (bitCnt != BW'(WORD_WIDTH - 1)) begin
          mosi <= txShift[WORD_WIDTH-1];
          txShift <= txShift << 1;
        end
      end
      // two cycles after the rise, the synchroniser output holds miso as it was at the rise
      if (state == SHIFT && sck && cnt == CW'(1)) rxShift <= {rxShift[WORD_WIDTH-2:0], misoSync[1]};
      if (wordEnd) begin
        if (!rRequest || rDone) begin
          rData <= rxShift;
          rRequest <= 1'b1;
        end else overflow <= 1'b1;
      end else if (rDone) rRequest <= 1'b0;
      if (stateNext == GAP) begin
        nCS <= 1'b1;
        mosi <= 1'b0;
      end
    end
  end
endmodule
